// File: rtl/lsu_ctrl.sv
// Load/store unit controller: issues a single word-aligned bus transfer for each
// accepted memory op. It lane-aligns store data and extracts and extends load data.
module lsu_ctrl #(
    parameter int BUS_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic [1:0]  mem_rw_i,
    input  logic [1:0]  byte_sel_i,
    input  logic        un_sign_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    input  logic [4:0]  rd_waddr_i,
    output logic        stall_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_ready_i,
    input  logic [31:0] bus_rdata_i,
    output logic        rd_we_o,
    output logic [4:0]  rd_waddr_o,
    output logic [31:0] rd_wdata_o,
    output logic        misalign_o,
    output logic        fault_o
);

    localparam logic [1:0] MEM_DISABLE = 2'b00;
    localparam logic [1:0] MEM_READ    = 2'b01;
    localparam logic [1:0] MEM_WRITE   = 2'b10;
    localparam logic [1:0] SL_BYTE     = 2'b00;
    localparam logic [1:0] SL_HALFWORD = 2'b01;
    localparam logic [1:0] SL_WORD     = 2'b10;
    localparam logic [1:0] SL_NONE     = 2'b11;
    localparam logic       UNSIGNED    = 1'b1;
    localparam logic [7:0] TO_LAST     = 8'(BUS_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUS,
        S_RESP
    } state_t;

    state_t      r_state;
    logic [7:0]  r_cnt;
    logic        r_bus_req;
    logic        r_bus_we;
    logic [31:0] r_bus_addr;
    logic [31:0] r_bus_wdata;
    logic [3:0]  r_bus_be;
    logic        r_rd_we;
    logic [4:0]  r_rd_waddr;
    logic [31:0] r_rd_wdata;

    // Request fields needed after BUS entry to shape the load result.
    logic [1:0]  r_off;
    logic [1:0]  r_size;
    logic        r_unsign;
    logic [4:0]  r_rd;

    logic w_idle;
    logic w_mem_op;
    logic w_aligned;
    logic w_accept;
    logic w_misalign;
    logic w_sel_none;
    logic w_timeout;

    function automatic logic [3:0] lane_be(input logic [1:0] sel, input logic [1:0] off,
                                           input logic we);
        logic [3:0] be;
        be = 4'b1111;
        if (we) begin
            case (sel)
                SL_BYTE:     be = 4'b0001 << off;
                SL_HALFWORD: be = off[1] ? 4'b1100 : 4'b0011;
                default:     be = 4'b1111;
            endcase
        end
        return be;
    endfunction

    function automatic logic [31:0] lane_wdata(input logic [1:0] sel, input logic [31:0] d);
        logic [31:0] w;
        case (sel)
            SL_BYTE:     w = {4{d[7:0]}};
            SL_HALFWORD: w = {2{d[15:0]}};
            default:     w = d;
        endcase
        return w;
    endfunction

    function automatic logic [31:0] load_ext(input logic [1:0] sel, input logic [1:0] off,
                                             input logic uns, input logic [31:0] rdata);
        logic [31:0] sh;
        logic [31:0] r;
        sh = rdata >> {off, 3'b000};
        case (sel)
            SL_BYTE:     r = (uns == UNSIGNED) ? {24'd0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SL_HALFWORD: r = (uns == UNSIGNED) ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:     r = rdata;
        endcase
        return r;
    endfunction

    assign w_idle     = (r_state == S_IDLE);
    assign w_mem_op   = req_i & (mem_rw_i != MEM_DISABLE);
    assign w_sel_none = w_idle & w_mem_op & (byte_sel_i == SL_NONE);

    always_comb begin
        w_aligned = 1'b1;
        case (byte_sel_i)
            SL_HALFWORD: w_aligned = ~addr_i[0];
            SL_WORD:     w_aligned = (addr_i[1:0] == 2'b00);
            default:     w_aligned = 1'b1;
        endcase
    end

    assign w_accept   = w_idle & w_mem_op & (byte_sel_i != SL_NONE) & w_aligned;
    assign w_misalign = w_idle & w_mem_op & (byte_sel_i != SL_NONE) & ~w_aligned;
    assign w_timeout  = (r_state == S_BUS) & ~bus_ready_i & (r_cnt == TO_LAST);

    // Exception pulses and stall are combinational; rst gates them so reset forces 0.
    assign stall_o    = rst & ((r_state == S_BUS) | w_accept);
    assign misalign_o = rst & w_misalign;
    assign fault_o    = rst & (w_sel_none | w_timeout);

    assign bus_req_o   = r_bus_req;
    assign bus_we_o    = r_bus_we;
    assign bus_addr_o  = r_bus_addr;
    assign bus_wdata_o = r_bus_wdata;
    assign bus_be_o    = r_bus_be;
    assign rd_we_o     = r_rd_we;
    assign rd_waddr_o  = r_rd_waddr;
    assign rd_wdata_o  = r_rd_wdata;

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_off    <= addr_i[1:0];
            r_size   <= byte_sel_i;
            r_unsign <= un_sign_i;
            r_rd     <= rd_waddr_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 8'd0;
            r_bus_req   <= 1'b0;
            r_bus_we    <= 1'b0;
            r_bus_addr  <= 32'd0;
            r_bus_wdata <= 32'd0;
            r_bus_be    <= 4'd0;
            r_rd_we     <= 1'b0;
            r_rd_waddr  <= 5'd0;
            r_rd_wdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state     <= S_BUS;
                        r_cnt       <= 8'd0;
                        r_bus_req   <= 1'b1;
                        r_bus_we    <= (mem_rw_i == MEM_WRITE);
                        r_bus_addr  <= {addr_i[31:2], 2'b00};
                        r_bus_be    <= lane_be(byte_sel_i, addr_i[1:0], mem_rw_i == MEM_WRITE);
                        r_bus_wdata <= (mem_rw_i == MEM_WRITE) ? lane_wdata(byte_sel_i, wdata_i)
                                                               : 32'd0;
                    end
                end
                S_BUS: begin
                    if (bus_ready_i || r_cnt == TO_LAST) begin
                        r_bus_req   <= 1'b0;
                        r_bus_we    <= 1'b0;
                        r_bus_addr  <= 32'd0;
                        r_bus_wdata <= 32'd0;
                        r_bus_be    <= 4'd0;
                        r_state     <= S_IDLE;
                        // Ready wins over a simultaneous timeout.
                        if (bus_ready_i && !r_bus_we) begin
                            r_state    <= S_RESP;
                            r_rd_we    <= (r_rd != 5'd0);
                            r_rd_waddr <= r_rd;
                            r_rd_wdata <= load_ext(r_size, r_off, r_unsign, bus_rdata_i);
                        end
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    r_rd_we    <= 1'b0;
                    r_rd_waddr <= 5'd0;
                    r_rd_wdata <= 32'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: bus transactions and load write-backs are queued
// when a request is driven and compared by a monitor as the DUT produces them.
module tb_lsu_ctrl;

    localparam logic [1:0] MEM_DISABLE = 2'b00;
    localparam logic [1:0] MEM_READ    = 2'b01;
    localparam logic [1:0] MEM_WRITE   = 2'b10;
    localparam logic [1:0] SL_BYTE     = 2'b00;
    localparam logic [1:0] SL_HALFWORD = 2'b01;
    localparam logic [1:0] SL_WORD     = 2'b10;
    localparam logic [1:0] SL_NONE     = 2'b11;
    localparam int         TO          = 16;

    logic        clk;
    logic        rst;
    logic        req_i;
    logic [1:0]  mem_rw_i;
    logic [1:0]  byte_sel_i;
    logic        un_sign_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [4:0]  rd_waddr_i;
    logic        stall_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_be_o;
    logic        bus_ready_i;
    logic [31:0] bus_rdata_i;
    logic        rd_we_o;
    logic [4:0]  rd_waddr_o;
    logic [31:0] rd_wdata_o;
    logic        misalign_o;
    logic        fault_o;

    lsu_ctrl #(.BUS_TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .mem_rw_i(mem_rw_i), .byte_sel_i(byte_sel_i),
        .un_sign_i(un_sign_i), .addr_i(addr_i), .wdata_i(wdata_i), .rd_waddr_i(rd_waddr_i),
        .stall_o(stall_o), .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o),
        .bus_wdata_o(bus_wdata_o), .bus_be_o(bus_be_o), .bus_ready_i(bus_ready_i),
        .bus_rdata_i(bus_rdata_i), .rd_we_o(rd_we_o), .rd_waddr_o(rd_waddr_o),
        .rd_wdata_o(rd_wdata_o), .misalign_o(misalign_o), .fault_o(fault_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
    } bus_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_t;

    bus_t bus_q[$];
    wb_t  wb_q[$];
    wb_t  wb_e;
    logic prev_req = 1'b0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [128:0] w_all_out;
    assign w_all_out = {stall_o, bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o, bus_be_o,
                        rd_we_o, rd_waddr_o, rd_wdata_o, misalign_o, fault_o};

    always @(negedge clk) begin
        if (bus_req_o) begin
            n_checks++;
            if (bus_q.size() == 0) begin
                n_fail++;
                $display("FAIL bus_unexpected actual addr=%h required no request", bus_addr_o);
            end else if (bus_addr_o !== bus_q[0].addr || bus_we_o !== bus_q[0].we ||
                         bus_be_o !== bus_q[0].be ||
                         (bus_q[0].we && bus_wdata_o !== bus_q[0].wdata)) begin
                n_fail++;
                $display("FAIL bus_txn actual addr=%h we=%b be=%b wdata=%h required addr=%h we=%b be=%b wdata=%h",
                         bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o,
                         bus_q[0].addr, bus_q[0].we, bus_q[0].be, bus_q[0].wdata);
            end
        end else if (prev_req && bus_q.size() > 0) begin
            void'(bus_q.pop_front());
        end
        if (rd_we_o) begin
            n_checks++;
            if (wb_q.size() == 0) begin
                n_fail++;
                $display("FAIL wb_unexpected actual rd=%0d data=%h required no write-back",
                         rd_waddr_o, rd_wdata_o);
            end else begin
                wb_e = wb_q.pop_front();
                if (rd_waddr_o !== wb_e.rd || rd_wdata_o !== wb_e.data) begin
                    n_fail++;
                    $display("FAIL wb_data actual rd=%0d data=%h required rd=%0d data=%h",
                             rd_waddr_o, rd_wdata_o, wb_e.rd, wb_e.data);
                end
            end
        end
        prev_req <= bus_req_o;
    end

    function automatic int sel_bytes(input logic [1:0] sel);
        return (sel == SL_BYTE) ? 1 : (sel == SL_HALFWORD) ? 2 : 4;
    endfunction

    function automatic logic [31:0] m_load(input logic [1:0] sel, input int off,
                                           input logic uns, input logic [31:0] word);
        int n;
        logic [31:0] v;
        logic s;
        n = sel_bytes(sel);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = word[8*(off+i) +: 8];
        s = v[8*n-1];
        for (int i = n; i < 4; i++) v[8*i +: 8] = (uns || !s) ? 8'h00 : 8'hFF;
        return v;
    endfunction

    function automatic logic [3:0] m_be(input logic [1:0] sel, input int off, input logic we);
        logic [3:0] be;
        if (!we) return 4'b1111;
        be = '0;
        for (int i = 0; i < sel_bytes(sel); i++) be[off+i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] m_wdata(input logic [1:0] sel, input logic [31:0] d);
        logic [31:0] w;
        int n;
        n = sel_bytes(sel);
        for (int l = 0; l < 4; l++) w[8*l +: 8] = d[8*(l % n) +: 8];
        return w;
    endfunction

    task automatic drive_idle();
        req_i = 1'b0; mem_rw_i = MEM_DISABLE; byte_sel_i = SL_NONE; un_sign_i = 1'b0;
        addr_i = '0; wdata_i = '0; rd_waddr_i = '0; bus_ready_i = 1'b0; bus_rdata_i = '0;
    endtask

    // Drives one request and its bus phase; ready arrives in BUS cycle waits+1.
    task automatic xfer(input logic [1:0] rw, input logic [1:0] sel, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [31:0] rdata, input int waits,
                        output logic acc_stall, output logic bus1_stall, output int fault_cyc,
                        output logic end_stall, output logic end_req, output logic end_fault);
        @(posedge clk); #1;
        req_i = 1'b1; mem_rw_i = rw; byte_sel_i = sel; un_sign_i = uns;
        addr_i = addr; wdata_i = wd; rd_waddr_i = rd;
        @(negedge clk);
        acc_stall = stall_o;
        bus1_stall = 1'b0;
        fault_cyc = 0;
        for (int k = 1; k <= TO; k++) begin
            @(posedge clk); #1;
            req_i = 1'b1; mem_rw_i = MEM_READ; byte_sel_i = SL_NONE; addr_i = 32'h3;
            if (k == waits + 1) begin
                bus_ready_i = 1'b1;
                bus_rdata_i = rdata;
            end
            @(negedge clk);
            if (k == 1) bus1_stall = stall_o;
            if (fault_o && fault_cyc == 0) fault_cyc = k;
            if (k == waits + 1) break;
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        end_stall = stall_o;
        end_req = bus_req_o;
        end_fault = fault_o;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        drive_idle();
        req_i = 1'b1; mem_rw_i = MEM_WRITE; byte_sel_i = SL_WORD; addr_i = 32'h40;
        @(negedge clk);
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs actual=%h required=0", w_all_out);
        end
        drive_idle();
        rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL post_reset_idle actual=%h required=0", w_all_out);
        end
    endtask

    task automatic test_store_word();
        logic as, bs, es, er, ef;
        int fc;
        bus_q.push_back('{32'h100, 1'b1, 4'b1111, 32'hDEADBEEF});
        xfer(MEM_WRITE, SL_WORD, 1'b0, 32'h100, 32'hDEADBEEF, 5'd7, 32'h0, 0,
             as, bs, fc, es, er, ef);
        n_checks++;
        if ({as, bs, es, er} !== 4'b1100) begin
            n_fail++;
            $display("FAIL sw_stall actual T/T+1/T+2 stall=%b%b%b req=%b required stall=110 req=0",
                     as, bs, es, er);
        end
        n_checks++;
        if (fc !== 0) begin
            n_fail++;
            $display("FAIL sw_fault actual cycle=%0d required 0", fc);
        end
    endtask

    task automatic test_loads();
        logic as, bs, es, er, ef;
        int fc;
        logic [31:0] mw;
        mw = 32'h8899AABB;
        bus_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{5'd3, 32'hFFFFFF88});
        xfer(MEM_READ, SL_BYTE, 1'b0, 32'h103, 32'h0, 5'd3, mw, 0, as, bs, fc, es, er, ef);
        n_checks++;
        if ({as, bs, es} !== 3'b110) begin
            n_fail++;
            $display("FAIL lb_latency actual stall T/T+1/T+2=%b%b%b required 110", as, bs, es);
        end
        bus_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{5'd4, 32'h00000088});
        xfer(MEM_READ, SL_BYTE, 1'b1, 32'h103, 32'h0, 5'd4, mw, 1, as, bs, fc, es, er, ef);
        bus_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{5'd5, 32'h00008899});
        xfer(MEM_READ, SL_HALFWORD, 1'b1, 32'h102, 32'h0, 5'd5, mw, 2, as, bs, fc, es, er, ef);
        bus_q.push_back('{32'h100, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{5'd6, 32'hFFFFAABB});
        xfer(MEM_READ, SL_HALFWORD, 1'b0, 32'h100, 32'h0, 5'd6, mw, 0, as, bs, fc, es, er, ef);
        bus_q.push_back('{32'h104, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{5'd31, 32'h8899AABB});
        xfer(MEM_READ, SL_WORD, 1'b0, 32'h104, 32'h0, 5'd31, mw, 3, as, bs, fc, es, er, ef);
        n_checks++;
        if (es !== 1'b0 || er !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_end actual stall=%b req=%b required 0 0", es, er);
        end
    endtask

    task automatic test_store_sub();
        logic as, bs, es, er, ef;
        int fc;
        bus_q.push_back('{32'h200, 1'b1, 4'b0010, 32'h78787878});
        xfer(MEM_WRITE, SL_BYTE, 1'b0, 32'h201, 32'h12345678, 5'd1, 32'h0, 0,
             as, bs, fc, es, er, ef);
        bus_q.push_back('{32'h200, 1'b1, 4'b1100, 32'h56785678});
        xfer(MEM_WRITE, SL_HALFWORD, 1'b0, 32'h202, 32'h12345678, 5'd1, 32'h0, 1,
             as, bs, fc, es, er, ef);
        n_checks++;
        if (as !== 1'b1 || es !== 1'b0) begin
            n_fail++;
            $display("FAIL sh_stall actual accept=%b end=%b required 1 0", as, es);
        end
    endtask

    task automatic test_misalign();
        @(posedge clk); #1;
        req_i = 1'b1; mem_rw_i = MEM_READ; byte_sel_i = SL_WORD; addr_i = 32'h102; rd_waddr_i = 5'd2;
        @(negedge clk);
        n_checks++;
        if ({misalign_o, fault_o, stall_o, bus_req_o} !== 4'b1000) begin
            n_fail++;
            $display("FAIL lw_misalign actual mis/fault/stall/req=%b%b%b%b required 1000",
                     misalign_o, fault_o, stall_o, bus_req_o);
        end
        @(posedge clk); #1;
        mem_rw_i = MEM_WRITE; byte_sel_i = SL_HALFWORD; addr_i = 32'h201;
        @(negedge clk);
        n_checks++;
        if ({misalign_o, stall_o, bus_req_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL sh_misalign actual mis/stall/req=%b%b%b required 100",
                     misalign_o, stall_o, bus_req_o);
        end
        @(posedge clk); #1;
        drive_idle();
        @(negedge clk);
        n_checks++;
        if ({misalign_o, bus_req_o, stall_o} !== 3'b000) begin
            n_fail++;
            $display("FAIL misalign_pulse actual mis/req/stall=%b%b%b required 000",
                     misalign_o, bus_req_o, stall_o);
        end
    endtask

    task automatic test_sel_none();
        @(posedge clk); #1;
        req_i = 1'b1; mem_rw_i = MEM_WRITE; byte_sel_i = SL_NONE; addr_i = 32'h10;
        @(negedge clk);
        n_checks++;
        if ({fault_o, misalign_o, stall_o} !== 3'b100) begin
            n_fail++;
            $display("FAIL sel_none actual fault/mis/stall=%b%b%b required 100",
                     fault_o, misalign_o, stall_o);
        end
        @(posedge clk); #1;
        mem_rw_i = MEM_DISABLE;
        @(negedge clk);
        n_checks++;
        if ({fault_o, stall_o} !== 2'b00) begin
            n_fail++;
            $display("FAIL disabled_op actual fault/stall=%b%b required 00", fault_o, stall_o);
        end
        @(posedge clk); #1;
        drive_idle();
    endtask

    task automatic test_timeout();
        logic as, bs, es, er, ef;
        int fc;
        bus_q.push_back('{32'h300, 1'b0, 4'b1111, 32'h0});
        xfer(MEM_READ, SL_WORD, 1'b0, 32'h300, 32'h0, 5'd9, 32'h0, 1000, as, bs, fc, es, er, ef);
        n_checks++;
        if (fc !== TO) begin
            n_fail++;
            $display("FAIL timeout_cycle actual=%0d required=%0d", fc, TO);
        end
        n_checks++;
        if ({er, es, ef} !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_exit actual req/stall/fault=%b%b%b required 000", er, es, ef);
        end
        bus_q.push_back('{32'h304, 1'b0, 4'b1111, 32'h0});
        wb_q.push_back('{5'd9, 32'hCAFEF00D});
        xfer(MEM_READ, SL_WORD, 1'b0, 32'h304, 32'h0, 5'd9, 32'hCAFEF00D, TO - 1,
             as, bs, fc, es, er, ef);
        n_checks++;
        if (fc !== 0) begin
            n_fail++;
            $display("FAIL ready_last_fault actual cycle=%0d required 0", fc);
        end
    endtask

    task automatic test_reset_midbus();
        bus_q.push_back('{32'h400, 1'b0, 4'b1111, 32'h0});
        @(posedge clk); #1;
        req_i = 1'b1; mem_rw_i = MEM_READ; byte_sel_i = SL_WORD; addr_i = 32'h400; rd_waddr_i = 5'd12;
        @(posedge clk); #1;
        drive_idle();
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL async_reset actual=%h required=0", w_all_out);
        end
        @(posedge clk); #1;
        bus_ready_i = 1'b1; bus_rdata_i = 32'h11223344;
        @(negedge clk);
        n_checks++;
        if (w_all_out !== '0) begin
            n_fail++;
            $display("FAIL reset_ready actual=%h required=0", w_all_out);
        end
        @(posedge clk); #1;
        bus_ready_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (w_all_out !== '0) begin
                n_fail++;
                $display("FAIL post_abort_idle actual=%h required=0", w_all_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic as, bs, es, er, ef;
        int fc;
        logic [1:0] rw, sel;
        logic uns;
        int off, waits;
        logic [31:0] a, d, md;
        logic [4:0] rd;
        for (int i = 0; i < 24; i++) begin
            rw = ($urandom_range(1, 0) == 1) ? MEM_WRITE : MEM_READ;
            sel = 2'($urandom_range(2, 0));
            uns = 1'($urandom_range(1, 0));
            off = (sel == SL_BYTE) ? $urandom_range(3, 0) : (sel == SL_HALFWORD) ? 2 * $urandom_range(1, 0) : 0;
            a = {$urandom_range(32'h0FFF, 0), 4'h0} | 32'(off);
            d = $urandom;
            md = $urandom;
            rd = (i % 6 == 0) ? 5'd0 : 5'($urandom_range(31, 1));
            waits = $urandom_range(3, 0);
            bus_q.push_back('{{a[31:2], 2'b00}, rw == MEM_WRITE, m_be(sel, off, rw == MEM_WRITE),
                              m_wdata(sel, d)});
            if (rw == MEM_READ && rd != 5'd0) wb_q.push_back('{rd, m_load(sel, off, uns, md)});
            xfer(rw, sel, uns, a, d, rd, md, waits, as, bs, fc, es, er, ef);
            n_checks++;
            if ({as, bs, es, er} !== 4'b1100 || fc !== 0) begin
                n_fail++;
                $display("FAIL b2b_ctrl[%0d] actual stall=%b%b%b req=%b fault=%0d required stall=110 req=0 fault=0",
                         i, as, bs, es, er, fc);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

    initial begin
        drive_idle();
        test_reset();
        test_store_word();
        test_loads();
        test_store_sub();
        test_misalign();
        test_sel_none();
        test_timeout();
        test_reset_midbus();
        test_back_to_back();
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus_q.size() !== 0 || wb_q.size() !== 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain actual bus=%0d wb=%0d required 0 0",
                     bus_q.size(), wb_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/lsu_ctrl.md
LSU_CTRL -- requirements
Module: lsu_ctrl

Interface
REQ-001 Parameter BUS_TIMEOUT, default 16, is the maximum number of cycles in BUS before the transfer is abandoned (legal range 2..255).
REQ-002 clk  in  1  sole clock; all state updates on its rising edge.
REQ-003 rst  in  1  reset, asynchronous, active-low.
REQ-004 req_i  in  1  memory operation valid from executrol.
REQ-005 mem_rw_i  in  `MEM_RW  MEM_READ / MEM_WRITE / MEM_DISABLE, encoded per defines.v.
REQ-006 byte_sel_i  in  `BYTE_SEL  SL_BYTE / SL_HALFWORD / SL_WORD / SL_NONE.
REQ-007 un_sign_i  in  1  UNSIGNED/SIGNED load extension.
REQ-008 addr_i  in  32  effective byte address.
REQ-009 wdata_i  in  32  store data (rs2).
REQ-010 rd_waddr_i  in  `REG_ADDR_WIDTH  load destination register.
REQ-011 stall_o  out  1  freeze upstream pipeline.
REQ-012 bus_req_o, bus_we_o  out  1 each  bus request and write strobe.
REQ-013 bus_addr_o  out  32  word-aligned address ({addr[31:2],2'b00}).
REQ-014 bus_wdata_o  out  32 and bus_be_o  out  4  lane-aligned write data and byte enables.
REQ-015 bus_ready_i  in  1 and bus_rdata_i  in  32  transfer complete and read data.
REQ-016 rd_we_o  out  1, rd_waddr_o  out  `REG_ADDR_WIDTH, rd_wdata_o  out  32  load write-back.
REQ-017 misalign_o  out  1 and fault_o  out  1  single-cycle exception pulses.

Function
REQ-018 FSM states IDLE, BUS, RESP; only IDLE samples req_i; req_i is ignored in BUS and RESP.
REQ-019 Accept = IDLE & req_i & mem_rw_i!=MEM_DISABLE & byte_sel_i!=SL_NONE & aligned; on accept, latch all inputs and go to BUS.
REQ-020 Aligned: byte always; halfword needs addr_i[0]=0; word needs addr_i[1:0]=0.
REQ-021 IDLE & req_i & memory op & misaligned: misalign_o=1 for that cycle only, no bus activity, stay IDLE.
REQ-022 IDLE & req_i & memory op & byte_sel_i=SL_NONE: fault_o=1 for one cycle, stay IDLE.
REQ-023 Registered bus outputs: bus_req_o=1 throughout BUS; bus_addr_o/we/be/wdata constant from BUS entry until exit.
REQ-024 Byte enables: byte 4'b0001<<addr[1:0]; halfword addr[1]?4'b1100:4'b0011; word 4'b1111; bus_be_o=4'b1111 for reads.
REQ-025 Store data: byte replicated to all four lanes; halfword replicated to both halves; word passed through.
REQ-026 BUS & bus_ready_i: a store returns to IDLE; a load captures bus_rdata_i and goes to RESP.
REQ-027 Load data: shift bus_rdata_i right by 8*addr[1:0], then zero-extend (UNSIGNED) or sign-extend (SIGNED) from bit 7 or bit 15; word loads are unmodified.
REQ-028 RESP lasts exactly one cycle: rd_we_o=1 (0 if rd_waddr is x0) and rd_wdata_o/rd_waddr_o valid; then IDLE.
REQ-029 Timeout counter clears on BUS entry and increments each BUS cycle without ready.
REQ-030 When the counter reaches BUS_TIMEOUT-1 without ready: fault_o pulse, bus_req_o drops next cycle, go to IDLE, no write-back.
REQ-031 If bus_ready_i arrives in the timeout cycle, ready wins and no fault is raised.
REQ-032 stall_o = (state==BUS) | (IDLE & accept); stall_o=0 in RESP and IDLE otherwise.
REQ-033 Latency with zero-wait ready: accept at T, bus_req_o at T+1, load write-back at T+2, stall_o low at T+2.
REQ-034 rd_we_o, misalign_o and fault_o are never asserted in the same cycle.

Reset
REQ-035 rst low forces, immediately and asynchronously: state IDLE, counter 0, every output 0.
REQ-036 Reset during BUS or RESP aborts the transfer: bus_req_o drops immediately, no write-back, no fault pulse.
REQ-037 After rst rises, the first edge behaves as IDLE.

Verification
REQ-038 SW of 0xDEADBEEF to 0x100, ready at T+1 -> bus_be_o=1111, bus_addr_o=0x100, bus_we_o=1, stall_o high for T and T+1.
REQ-039 Memory word 0x8899AABB, LB @0x103 -> rd_wdata_o=0xFFFFFF88; LBU -> 0x00000088; LHU @0x102 -> 0x00008899.
REQ-040 SB 0x12345678 @0x201 -> bus_be_o=0010, bus_wdata_o=0x78787878; SH @0x202 -> be=1100, wdata=0x56785678.
REQ-041 LW @0x102 -> misalign_o one-cycle pulse, bus_req_o stays 0, stall_o 0.
REQ-042 LW with bus_ready_i held low -> fault_o pulse after 16 BUS cycles, bus_req_o falls, no rd_we_o; a repeat with ready in the 16th cycle -> normal write-back, no fault.
REQ-043 rst low during BUS of a load, then ready pulse -> no rd_we_o; all outputs 0 until the next accepted request.
